dff_delay_line: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage delay line.
- Adds a clock enable, synchronous clear, a runtime-selectable output tap, a valid bit carried alongside the data, and a fill/primed indicator.
- Used wherever a datapath must be re-aligned by a known, programmable number of enabled cycles.

---
 rtl/dff_delay_line_pkg.sv | 18 +
 rtl/dff_delay_stage.sv | 35 +++
 rtl/dff_delay_line.sv | 82 ++++++++
 tb/tb_dff_delay_line.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_delay_line_pkg.sv
// rtl/dff_delay_line_pkg.sv - shared sizing helpers for the delay line
package dff_delay_line_pkg;

  // Ceiling log2, never less than 1 so a select or counter keeps at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEPTH_DEFAULT = 4;
  localparam int TAPW          = clog2(DEPTH_DEFAULT);
  localparam int CNTW          = clog2(DEPTH_DEFAULT + 1);

endpackage

// File: rtl/dff_delay_stage.sv
// rtl/dff_delay_stage.sv - one {valid, data} register with clear and enable
module dff_delay_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - WIDTH x DEPTH delay line with valid, tap select and fill flag
module dff_delay_line
  import dff_delay_line_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAPW  = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  input  logic [TAPW-1:0]  TAP_SEL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             Q_VALID,
  output logic             PRIMED
);

  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH:0]   stage_in  [DEPTH];
  logic [WIDTH:0]   stage_out [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH:0]   sel;
  int               tap_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_in[gi] = {D_VALID, D};
    end else begin : g_tail
      assign stage_in[gi] = stage_out[gi-1];
    end

    dff_delay_stage #(
      .W(WIDTH + 1)
    ) u_stage (
      .clk  (CLK),
      .rst_n(RESET),
      .clr  (CLR),
      .en   (EN),
      .d    (stage_in[gi]),
      .q    (stage_out[gi])
    );
  end

  // Counts enabled shifts, not valid samples; saturates once every stage is written.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN && (cnt_q != CNT_W'(DEPTH))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Taps beyond the last stage clamp to it when DEPTH is not a power of two.
  always_comb begin
    tap_idx = (int'(TAP_SEL) < DEPTH) ? int'(TAP_SEL) : DEPTH - 1;
    sel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == tap_idx) sel = stage_out[i];
    end
  end

  assign Q       = sel[WIDTH-1:0];
  assign Q_VALID = sel[WIDTH];
  assign Qbar    = ~sel[WIDTH-1:0];
  assign PRIMED  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// tb/tb_dff_delay_line.sv - randomized and directed checks of dff_delay_line against a sample-log model
module tb_dff_delay_line;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] D = 8'h00;
  logic       D_VALID = 1'b0;
  logic [1:0] TAP_SEL = 2'd0;
  logic [1:0] TAP_SEL3 = 2'd0;
  logic [7:0] Q, Qbar, Q3, Qbar3;
  logic       Q_VALID, PRIMED, Q_VALID3, PRIMED3;

  int n_cmp = 0;
  int n_fail = 0;

  dff_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .D(D), .D_VALID(D_VALID),
    .TAP_SEL(TAP_SEL), .Q(Q), .Qbar(Qbar), .Q_VALID(Q_VALID), .PRIMED(PRIMED)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .D(D), .D_VALID(D_VALID),
    .TAP_SEL(TAP_SEL3), .Q(Q3), .Qbar(Qbar3), .Q_VALID(Q_VALID3), .PRIMED(PRIMED3)
  );

  always #5 CLK = ~CLK;

  // Model: a log of every enabled sample; reset/clear just hide everything logged so far.
  logic [8:0] mlog [4096];
  int wr = 0;
  int base = 0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      base <= wr;
    end else if (CLR) begin
      base <= wr;
    end else if (EN) begin
      mlog[wr % 4096] <= {D_VALID, D};
      wr <= wr + 1;
    end
  end

  function automatic logic [8:0] model_at(input int tap, input int depth);
    int t;
    int idx;
    t   = (tap < depth) ? tap : depth - 1;
    idx = wr - 1 - t;
    if (idx >= base) return mlog[idx % 4096];
    return 9'h000;
  endfunction

  function automatic logic model_primed(input int depth);
    return (wr - base) >= depth;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [8:0] e4;
    logic [8:0] e3;
    e4 = model_at(int'(TAP_SEL), 4);
    e3 = model_at(int'(TAP_SEL3), 3);
    chk("q4", {24'h0, Q}, {24'h0, e4[7:0]});
    chk("qbar4", {24'h0, Qbar}, {24'h0, ~e4[7:0]});
    chk("qv4", {31'h0, Q_VALID}, {31'h0, e4[8]});
    chk("primed4", {31'h0, PRIMED}, {31'h0, model_primed(4)});
    chk("q3", {24'h0, Q3}, {24'h0, e3[7:0]});
    chk("qv3", {31'h0, Q_VALID3}, {31'h0, e3[8]});
    chk("primed3", {31'h0, PRIMED3}, {31'h0, model_primed(3)});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"}, {24'h0, Q}, 32'h00);
    chk({tag, "_qbar"}, {24'h0, Qbar}, 32'hFF);
    chk({tag, "_qv"}, {31'h0, Q_VALID}, 32'h0);
    chk({tag, "_primed"}, {31'h0, PRIMED}, 32'h0);
  endtask

  logic [7:0] stream [5];

  initial begin
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    stream[3] = 8'h44; stream[4] = 8'h55;

    // Reset defaults
    step(); step();
    check_reset_outputs("rst");
    RESET = 1'b1;
    step();

    // Latency per tap and fill indicator
    EN = 1'b1; D_VALID = 1'b1; TAP_SEL = 2'd0;
    for (int k = 0; k < 5; k++) begin
      D = stream[k];
      step();
      if (k == 0) begin
        chk("lat_tap0", {24'h0, Q}, 32'h11);
        TAP_SEL = 2'd3;
      end
      if (k == 2) chk("primed_e3", {31'h0, PRIMED}, 32'h0);
      if (k == 3) begin
        chk("lat_tap3", {24'h0, Q}, 32'h11);
        chk("primed_e4", {31'h0, PRIMED}, 32'h1);
      end
      if (k == 4) chk("primed_e5", {31'h0, PRIMED}, 32'h1);
    end

    // Enable gating
    D = 8'hA5; TAP_SEL = 2'd0;
    step();
    EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      D = (k % 2 == 0) ? 8'h5A : 8'hC3;
      step();
      chk("hold_tap0", {24'h0, Q}, 32'hA5);
    end
    EN = 1'b1; D = 8'h00; TAP_SEL = 2'd2;
    step();
    step();
    chk("gate_tap2", {24'h0, Q}, 32'hA5);

    // Valid tracking
    CLR = 1'b1; EN = 1'b0;
    step();
    CLR = 1'b0; EN = 1'b1; TAP_SEL = 2'd3;
    for (int k = 0; k < 4; k++) begin
      D = 8'(k + 1);
      D_VALID = (k != 1);
      step();
    end
    chk("vld_q4", {24'h0, Q}, 32'h01);
    chk("vld_qv4", {31'h0, Q_VALID}, 32'h1);
    D = 8'h05; D_VALID = 1'b0;
    step();
    chk("vld_q5", {24'h0, Q}, 32'h02);
    chk("vld_qv5", {31'h0, Q_VALID}, 32'h0);

    // CLR beats EN
    CLR = 1'b1; EN = 1'b1; D = 8'hFF; D_VALID = 1'b1;
    step();
    CLR = 1'b0; EN = 1'b0;
    chk("clr_q3", {24'h0, Q}, 32'h00);
    chk("clr_qv", {31'h0, Q_VALID}, 32'h0);
    chk("clr_primed", {31'h0, PRIMED}, 32'h0);
    TAP_SEL = 2'd0; #1;
    chk("clr_q0", {24'h0, Q}, 32'h00);

    // TAP_SEL sweep with EN=0, plus clamp on the DEPTH=3 build
    EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      D = stream[k];
      step();
    end
    EN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      TAP_SEL = 2'(k);
      #1;
      chk("sweep", {24'h0, Q}, {24'h0, stream[3-k]});
    end
    TAP_SEL3 = 2'd3; #1;
    chk("clamp3", {24'h0, Q3}, 32'h22);
    TAP_SEL3 = 2'd2; #1;
    chk("tap3_2", {24'h0, Q3}, 32'h22);

    // Asynchronous reset between edges
    EN = 1'b1;
    step();
    #2;
    RESET = 1'b0;
    #1;
    check_reset_outputs("async");
    step();
    RESET = 1'b1;

    // Randomized traffic checked by the per-cycle compare process
    for (int n = 0; n < 600; n++) begin
      EN       = ($urandom_range(0, 9) < 7);
      CLR      = ($urandom_range(0, 39) == 0);
      D        = 8'($urandom);
      D_VALID  = 1'($urandom);
      TAP_SEL  = 2'($urandom);
      TAP_SEL3 = 2'($urandom);
      step();
      if ($urandom_range(0, 59) == 0) begin
        #2;
        RESET = 1'b0;
        #1;
        check_reset_outputs("rand_async");
        step();
        RESET = 1'b1;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
